noc_flit_sink: RTL

- Per-node packet receiver/checker at the ejection port of the spidergon NoC; the consuming end of the flits the traffic injector drives into `data_input`.
- Accepts one flit per cycle over valid/ready and reassembles packets independently per virtual channel.
- Checks framing and destination, then reports each completed packet plus running packet/error counters.

---
 rtl/noc_flit_sink.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/noc_flit_sink.sv
// Ejection-port packet sink: reassembles packets per virtual channel, checks
// framing and destination, and reports completed packets plus error counters.
module noc_flit_sink #(
  parameter  int NUM_OF_NODES            = 8,
  parameter  int FLIT_DATA_WIDTH         = 16,
  parameter  int NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter  int NODE_ID                 = 0,
  parameter  int MAX_PKT_LEN             = 16,
  localparam int DEST_NODE_WIDTH         = $clog2(NUM_OF_NODES),
  localparam int VC_W                    = (NUM_OF_VIRTUAL_CHANNELS > 1) ?
                                           $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1,
  localparam int LEN_W                   = $clog2(MAX_PKT_LEN + 1),
  localparam int FLIT_TOTAL_WIDTH        = 2 + VC_W + FLIT_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [FLIT_TOTAL_WIDTH-1:0] flit_in,
  input  logic                        flit_valid,
  output logic                        flit_ready,
  input  logic                        sink_stall,
  output logic                        pkt_done,
  output logic [DEST_NODE_WIDTH-1:0]  pkt_src,
  output logic [VC_W-1:0]             pkt_vc,
  output logic [LEN_W-1:0]            pkt_len,
  output logic                        pkt_misroute,
  output logic [FLIT_DATA_WIDTH-1:0]  data_output,
  output logic [15:0]                 pkt_count,
  output logic [15:0]                 err_count,
  output logic [3:0]                  err_sticky
);

  localparam int NVC = NUM_OF_VIRTUAL_CHANNELS;
  localparam int DW  = DEST_NODE_WIDTH;

  localparam logic [1:0] TYPE_TAIL   = 2'b00;
  localparam logic [1:0] TYPE_HEAD   = 2'b01;
  localparam logic [1:0] TYPE_BODY   = 2'b10;
  localparam logic [1:0] TYPE_HEADER = 2'b11;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_IN_PKT = 1'b1
  } vc_state_e;

  vc_state_e         state_q [NVC];
  vc_state_e         state_d [NVC];
  logic [LEN_W-1:0]  len_q   [NVC];
  logic [LEN_W-1:0]  len_d   [NVC];
  logic [DW-1:0]     src_q   [NVC];
  logic [DW-1:0]     src_d   [NVC];
  logic              mis_q   [NVC];
  logic              mis_d   [NVC];

  logic                       pkt_done_q, pkt_done_d;
  logic [DW-1:0]              pkt_src_q, pkt_src_d;
  logic [VC_W-1:0]            pkt_vc_q, pkt_vc_d;
  logic [LEN_W-1:0]           pkt_len_q, pkt_len_d;
  logic                       pkt_mis_q, pkt_mis_d;
  logic [FLIT_DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]                pkt_count_q, pkt_count_d;
  logic [15:0]                err_count_q, err_count_d;
  logic [3:0]                 err_sticky_q, err_sticky_d;

  logic [1:0]                 flit_type;
  logic [VC_W-1:0]            flit_vc;
  logic [FLIT_DATA_WIDTH-1:0] flit_data;
  logic [DW-1:0]              hdr_dest, hdr_src;
  logic                       hdr_misroute;
  logic                       accept;

  logic              vc_ok, cur_in_pkt, cur_mis, emit, wr;
  logic [LEN_W-1:0]  cur_len, len_inc, wr_len;
  logic [DW-1:0]     cur_src, wr_src;
  vc_state_e         wr_state;
  logic              wr_mis;
  logic [1:0]        err_inc;
  logic [16:0]       err_sum;

  assign flit_type    = flit_in[FLIT_TOTAL_WIDTH-1 -: 2];
  assign flit_vc      = flit_in[FLIT_DATA_WIDTH +: VC_W];
  assign flit_data    = flit_in[FLIT_DATA_WIDTH-1:0];
  assign hdr_dest     = flit_data[FLIT_DATA_WIDTH-1 -: DW];
  assign hdr_src      = flit_data[FLIT_DATA_WIDTH-1-DW -: DW];
  assign hdr_misroute = (hdr_dest != DW'(NODE_ID));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NVC; i++) begin
        state_q[i] <= VC_IDLE;
        len_q[i]   <= '0;
        src_q[i]   <= '0;
        mis_q[i]   <= 1'b0;
      end
      pkt_done_q   <= 1'b0;
      pkt_src_q    <= '0;
      pkt_vc_q     <= '0;
      pkt_len_q    <= '0;
      pkt_mis_q    <= 1'b0;
      data_q       <= '0;
      pkt_count_q  <= '0;
      err_count_q  <= '0;
      err_sticky_q <= '0;
    end else begin
      for (int i = 0; i < NVC; i++) begin
        state_q[i] <= state_d[i];
        len_q[i]   <= len_d[i];
        src_q[i]   <= src_d[i];
        mis_q[i]   <= mis_d[i];
      end
      pkt_done_q   <= pkt_done_d;
      pkt_src_q    <= pkt_src_d;
      pkt_vc_q     <= pkt_vc_d;
      pkt_len_q    <= pkt_len_d;
      pkt_mis_q    <= pkt_mis_d;
      data_q       <= data_d;
      pkt_count_q  <= pkt_count_d;
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    src_d        = src_q;
    mis_d        = mis_q;
    pkt_done_d   = 1'b0;
    pkt_src_d    = pkt_src_q;
    pkt_vc_d     = pkt_vc_q;
    pkt_len_d    = pkt_len_q;
    pkt_mis_d    = pkt_mis_q;
    data_d       = data_q;
    pkt_count_d  = pkt_count_q;
    err_sticky_d = err_sticky_q;
    err_inc      = 2'd0;
    emit         = 1'b0;
    vc_ok        = 1'b0;
    cur_in_pkt   = 1'b0;
    cur_len      = '0;
    cur_src      = '0;
    cur_mis      = 1'b0;

    // VC ids beyond the configured channel count simply never match here.
    for (int i = 0; i < NVC; i++) begin
      if (flit_vc == VC_W'(i)) begin
        vc_ok      = 1'b1;
        cur_in_pkt = (state_q[i] == VC_IN_PKT);
        cur_len    = len_q[i];
        cur_src    = src_q[i];
        cur_mis    = mis_q[i];
      end
    end

    len_inc  = (cur_len >= LEN_W'(MAX_PKT_LEN)) ? cur_len : cur_len + LEN_W'(1);
    wr       = 1'b0;
    wr_state = VC_IDLE;
    wr_len   = cur_len;
    wr_src   = cur_src;
    wr_mis   = cur_mis;

    if (accept) begin
      if (!vc_ok) begin
        err_inc         = err_inc + 2'd1;
        err_sticky_d[3] = 1'b1;
      end else begin
        case (flit_type)
          TYPE_HEADER: begin
            if (cur_in_pkt) begin
              err_inc         = err_inc + 2'd1;
              err_sticky_d[1] = 1'b1;
            end
            wr        = 1'b1;
            wr_state  = VC_IDLE;
            emit      = 1'b1;
            pkt_src_d = hdr_src;
            pkt_len_d = LEN_W'(1);
            pkt_mis_d = hdr_misroute;
          end
          TYPE_HEAD: begin
            if (cur_in_pkt) begin
              err_inc         = err_inc + 2'd1;
              err_sticky_d[1] = 1'b1;
            end
            wr       = 1'b1;
            wr_state = VC_IN_PKT;
            wr_len   = LEN_W'(1);
            wr_src   = hdr_src;
            wr_mis   = hdr_misroute;
          end
          TYPE_BODY: begin
            data_d = flit_data;
            if (cur_in_pkt) begin
              wr       = 1'b1;
              wr_state = VC_IN_PKT;
              wr_len   = len_inc;
            end else begin
              err_inc         = err_inc + 2'd1;
              err_sticky_d[2] = 1'b1;
            end
          end
          default: begin
            if (cur_in_pkt) begin
              data_d    = flit_data;
              wr        = 1'b1;
              wr_state  = VC_IDLE;
              emit      = 1'b1;
              pkt_src_d = cur_src;
              pkt_len_d = len_inc;
              pkt_mis_d = cur_mis;
            end else begin
              err_inc         = err_inc + 2'd1;
              err_sticky_d[2] = 1'b1;
            end
          end
        endcase
      end
    end

    // Misroute is charged once, when the packet is reported.
    if (emit) begin
      pkt_done_d  = 1'b1;
      pkt_vc_d    = flit_vc;
      pkt_count_d = pkt_count_q + 16'd1;
      if (pkt_mis_d) begin
        err_inc         = err_inc + 2'd1;
        err_sticky_d[0] = 1'b1;
      end
    end

    for (int i = 0; i < NVC; i++) begin
      if (wr && (flit_vc == VC_W'(i))) begin
        state_d[i] = wr_state;
        len_d[i]   = wr_len;
        src_d[i]   = wr_src;
        mis_d[i]   = wr_mis;
      end
    end

    err_sum     = {1'b0, err_count_q} + 17'(err_inc);
    err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_comb begin
    flit_ready = ~reset & ~sink_stall;
    accept     = flit_valid & flit_ready;
  end

  assign pkt_done     = pkt_done_q;
  assign pkt_src      = pkt_src_q;
  assign pkt_vc       = pkt_vc_q;
  assign pkt_len      = pkt_len_q;
  assign pkt_misroute = pkt_mis_q;
  assign data_output  = data_q;
  assign pkt_count    = pkt_count_q;
  assign err_count    = err_count_q;
  assign err_sticky   = err_sticky_q;

endmodule
